// File: rtl/memory_writeback_cycle_pkg.sv
// ============================================================================
// Module  : mwb_pkg
// Brief   : Shared types and constants for the memory / write-back stage.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package mwb_pkg;

  typedef enum logic [0:0] {
    MWB_IDLE = 1'b0,
    MWB_WAIT = 1'b1
  } mwb_state_t;

  localparam logic RESULT_SRC_ALU = 1'b0;
  localparam logic RESULT_SRC_MEM = 1'b1;

  typedef struct packed {
    logic        reg_write;
    logic [4:0]  rd;
    logic [31:0] result;
  } wb_t;

  localparam wb_t WB_BUBBLE = '{reg_write: 1'b0, rd: 5'd0, result: 32'd0};

endpackage

`default_nettype wire

// File: rtl/memory_writeback_cycle_mem_watchdog.sv
// ============================================================================
// Module  : mem_watchdog
// Brief   : WAIT-state cycle counter; flags an access that never completes.
//           Built only when MEM_TIMEOUT_EN is defined.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

`ifdef MEM_TIMEOUT_EN
module mem_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic active,
  input  logic done,
  output logic expired
);

  localparam logic [7:0] c_last = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= 8'd0;
    end else if (start) begin
      r_cnt <= 8'd0;
    end else if (active && !done) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  // Fires on the edge that ends the TIMEOUT_CYCLES-th unanswered WAIT cycle.
  assign expired = active && !done && (r_cnt == c_last);

endmodule
`endif

`default_nettype wire

// File: rtl/memory_writeback_cycle.sv
// ============================================================================
// Module  : memory_writeback_cycle
// Brief   : Memory-access / write-back stage with a ready/ack data port.
//           Optional access timeout enabled by MEM_TIMEOUT_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module memory_writeback_cycle
  import mwb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic        ResultSrcM,
  input  logic [4:0]  RD_M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic        StallM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        mem_err,
  output logic        RegWriteW,
  output logic [4:0]  RDW,
  output logic [31:0] ResultW
);

  mwb_state_t  r_state;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [4:0]  r_rd;
  logic        r_is_store;
  wb_t         r_wb;

  logic w_is_load;
  logic w_is_store;
  logic w_accept;
  logic w_waiting;
  logic w_expired;

  assign w_is_load  = (ResultSrcM == RESULT_SRC_MEM) & RegWriteM;
  assign w_is_store = MemWriteM;
  assign w_waiting  = (r_state == MWB_WAIT);
  assign w_accept   = (r_state == MWB_IDLE) & (w_is_load | w_is_store);

`ifdef MEM_TIMEOUT_EN
  logic r_mem_err;

  mem_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_mem_watchdog (
    .clk     (clk),
    .rst     (rst),
    .start   (w_accept),
    .active  (w_waiting),
    .done    (mem_ready),
    .expired (w_expired)
  );

  assign mem_err = r_mem_err;
`else
  assign w_expired = 1'b0;
  assign mem_err   = 1'b0;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES out of range 1..255");
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= MWB_IDLE;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_rd       <= 5'd0;
      r_is_store <= 1'b0;
      r_wb       <= WB_BUBBLE;
`ifdef MEM_TIMEOUT_EN
      r_mem_err  <= 1'b0;
`endif
    end else begin
`ifdef MEM_TIMEOUT_EN
      r_mem_err <= 1'b0;
`endif
      case (r_state)
        MWB_IDLE: begin
          if (w_accept) begin
            r_addr     <= ALUResultM;
            r_wdata    <= WriteDataM;
            r_rd       <= RD_M;
            r_is_store <= w_is_store;
            r_state    <= MWB_WAIT;
            r_wb       <= WB_BUBBLE;
          end else begin
            r_wb <= '{reg_write: RegWriteM, rd: RD_M, result: ALUResultM};
          end
        end
        MWB_WAIT: begin
          // A ready on the same edge as the timeout completes normally.
          if (mem_ready) begin
            r_state <= MWB_IDLE;
            if (r_is_store) r_wb <= WB_BUBBLE;
            else            r_wb <= '{reg_write: 1'b1, rd: r_rd, result: mem_rdata};
          end else if (w_expired) begin
            r_state <= MWB_IDLE;
            r_wb    <= WB_BUBBLE;
`ifdef MEM_TIMEOUT_EN
            r_mem_err <= 1'b1;
`endif
          end else begin
            r_wb <= WB_BUBBLE;
          end
        end
        default: begin
          r_state <= MWB_IDLE;
          r_wb    <= WB_BUBBLE;
        end
      endcase
    end
  end

  assign StallM    = w_waiting;
  assign mem_req   = w_waiting;
  assign mem_we    = w_waiting & r_is_store;
  assign mem_addr  = w_waiting ? r_addr  : 32'd0;
  assign mem_wdata = w_waiting ? r_wdata : 32'd0;

  assign RegWriteW = r_wb.reg_write;
  assign RDW       = r_wb.rd;
  assign ResultW   = r_wb.result;

endmodule

`default_nettype wire

// File: tb/tb_memory_writeback_cycle.sv
// ============================================================================
// Module  : tb_memory_writeback_cycle
// Brief   : Directed self-checking bench for memory_writeback_cycle
//           (timeout cases built when MEM_TIMEOUT_EN is defined).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_memory_writeback_cycle;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteM, MemWriteM, ResultSrcM;
  logic [4:0]  RD_M;
  logic [31:0] ALUResultM, WriteDataM;
  logic        StallM, mem_req, mem_we, mem_err;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        RegWriteW;
  logic [4:0]  RDW;
  logic [31:0] ResultW;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  memory_writeback_cycle #(
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .RegWriteM  (RegWriteM),
    .MemWriteM  (MemWriteM),
    .ResultSrcM (ResultSrcM),
    .RD_M       (RD_M),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .StallM     (StallM),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .mem_err    (mem_err),
    .RegWriteW  (RegWriteW),
    .RDW        (RDW),
    .ResultW    (ResultW)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_m(input logic rw, input logic mw, input logic src,
                         input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] wd);
    RegWriteM  = rw;
    MemWriteM  = mw;
    ResultSrcM = src;
    RD_M       = rd;
    ALUResultM = alu;
    WriteDataM = wd;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, ".stall"}, {31'd0, StallM}, 32'd0);
    check_eq({tag, ".req"},   {31'd0, mem_req}, 32'd0);
    check_eq({tag, ".we"},    {31'd0, mem_we}, 32'd0);
    check_eq({tag, ".addr"},  mem_addr, 32'd0);
    check_eq({tag, ".wdata"}, mem_wdata, 32'd0);
    check_eq({tag, ".err"},   {31'd0, mem_err}, 32'd0);
    check_eq({tag, ".rw"},    {31'd0, RegWriteW}, 32'd0);
    check_eq({tag, ".rd"},    {27'd0, RDW}, 32'd0);
    check_eq({tag, ".res"},   ResultW, 32'd0);
  endtask

  initial begin
    int stalls;
    rst = 1'b1;
    mem_ready = 1'b0;
    mem_rdata = 32'd0;
    drive_m(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;

    // ALU op, 1-cycle latency
    drive_m(1'b1, 1'b0, 1'b0, 5'd5, 32'h0000_1234, 32'd0);
    check_eq("alu.stall_pre", {31'd0, StallM}, 32'd0);
    tick();
    check_eq("alu.rw",    {31'd0, RegWriteW}, 32'd1);
    check_eq("alu.rd",    {27'd0, RDW}, 32'd5);
    check_eq("alu.res",   ResultW, 32'h0000_1234);
    check_eq("alu.stall", {31'd0, StallM}, 32'd0);
    drive_m(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    mem_ready = 1'b1;   // ready while IDLE must be ignored
    tick();
    mem_ready = 1'b0;
    check_eq("bubble.rw", {31'd0, RegWriteW}, 32'd0);

    // Load with ready in the 3rd WAIT cycle
    drive_m(1'b1, 1'b0, 1'b1, 5'd7, 32'h0000_0040, 32'h1111_1111);
    check_eq("ld.accept_stall", {31'd0, StallM}, 32'd0);
    tick();
    drive_m(1'b1, 1'b0, 1'b0, 5'd9, 32'h9999_9999, 32'd0);
    stalls = 0;
    for (int i = 1; i <= 3; i++) begin
      stalls += int'(StallM);
      check_eq("ld.addr", mem_addr, 32'h0000_0040);
      check_eq("ld.we",   {31'd0, mem_we}, 32'd0);
      check_eq("ld.req",  {31'd0, mem_req}, 32'd1);
      check_eq("ld.rw_wait", {31'd0, RegWriteW}, 32'd0);
      if (i == 3) begin
        mem_ready = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
      end
      tick();
    end
    mem_ready = 1'b0;
    mem_rdata = 32'd0;
    check_eq("ld.stall_cycles", 32'(stalls), 32'd3);
    check_eq("ld.stall_after", {31'd0, StallM}, 32'd0);
    check_eq("ld.req_after",   {31'd0, mem_req}, 32'd0);
    check_eq("ld.addr_after",  mem_addr, 32'd0);
    check_eq("ld.rw",  {31'd0, RegWriteW}, 32'd1);
    check_eq("ld.rd",  {27'd0, RDW}, 32'd7);
    check_eq("ld.res", ResultW, 32'hDEAD_BEEF);
    drive_m(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    tick();

    // Store, ready after 1 cycle
    drive_m(1'b0, 1'b1, 1'b0, 5'd0, 32'h0000_0080, 32'h0000_CAFE);
    tick();
    drive_m(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    check_eq("st.req",   {31'd0, mem_req}, 32'd1);
    check_eq("st.we",    {31'd0, mem_we}, 32'd1);
    check_eq("st.addr",  mem_addr, 32'h0000_0080);
    check_eq("st.wdata", mem_wdata, 32'h0000_CAFE);
    check_eq("st.rw_wait", {31'd0, RegWriteW}, 32'd0);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    check_eq("st.req_after",   {31'd0, mem_req}, 32'd0);
    check_eq("st.wdata_after", mem_wdata, 32'd0);
    check_eq("st.rw", {31'd0, RegWriteW}, 32'd0);
    tick();
    check_eq("st.rw2", {31'd0, RegWriteW}, 32'd0);

    // Load followed by held ALU op
    drive_m(1'b1, 1'b0, 1'b1, 5'd12, 32'h0000_0100, 32'd0);
    tick();
    drive_m(1'b1, 1'b0, 1'b0, 5'd3, 32'h0000_0055, 32'd0);
    check_eq("b2b.stall1", {31'd0, StallM}, 32'd1);
    tick();
    check_eq("b2b.stall2", {31'd0, StallM}, 32'd1);
    check_eq("b2b.rw_wait", {31'd0, RegWriteW}, 32'd0);
    mem_ready = 1'b1;
    mem_rdata = 32'h0BAD_F00D;
    tick();
    mem_ready = 1'b0;
    check_eq("b2b.ld_rd",  {27'd0, RDW}, 32'd12);
    check_eq("b2b.ld_res", ResultW, 32'h0BAD_F00D);
    check_eq("b2b.ld_rw",  {31'd0, RegWriteW}, 32'd1);
    tick();
    check_eq("b2b.alu_rw",  {31'd0, RegWriteW}, 32'd1);
    check_eq("b2b.alu_rd",  {27'd0, RDW}, 32'd3);
    check_eq("b2b.alu_res", ResultW, 32'h0000_0055);
    drive_m(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    tick();

`ifdef MEM_TIMEOUT_EN
    // Timeout with ready stuck low
    drive_m(1'b1, 1'b0, 1'b1, 5'd4, 32'h0000_0200, 32'd0);
    tick();
    drive_m(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    for (int i = 1; i <= 4; i++) begin
      check_eq("to.stall", {31'd0, StallM}, 32'd1);
      check_eq("to.err_wait", {31'd0, mem_err}, 32'd0);
      tick();
    end
    check_eq("to.stall_after", {31'd0, StallM}, 32'd0);
    check_eq("to.req_after",   {31'd0, mem_req}, 32'd0);
    check_eq("to.err",         {31'd0, mem_err}, 32'd1);
    check_eq("to.rw",          {31'd0, RegWriteW}, 32'd0);
    tick();
    check_eq("to.err_clear", {31'd0, mem_err}, 32'd0);
    check_eq("to.rw2", {31'd0, RegWriteW}, 32'd0);

    // Ready on the 4th cycle beats the timeout
    drive_m(1'b1, 1'b0, 1'b1, 5'd6, 32'h0000_0300, 32'd0);
    tick();
    drive_m(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    for (int i = 1; i <= 4; i++) begin
      check_eq("to4.stall", {31'd0, StallM}, 32'd1);
      if (i == 4) begin
        mem_ready = 1'b1;
        mem_rdata = 32'h1234_5678;
      end
      tick();
    end
    mem_ready = 1'b0;
    check_eq("to4.err", {31'd0, mem_err}, 32'd0);
    check_eq("to4.rw",  {31'd0, RegWriteW}, 32'd1);
    check_eq("to4.res", ResultW, 32'h1234_5678);
    tick();
    check_eq("to4.err2", {31'd0, mem_err}, 32'd0);
`else
    // Without the timeout, a long WAIT never raises an error
    drive_m(1'b1, 1'b0, 1'b1, 5'd4, 32'h0000_0200, 32'd0);
    tick();
    drive_m(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    for (int i = 1; i <= 8; i++) begin
      check_eq("nto.stall", {31'd0, StallM}, 32'd1);
      check_eq("nto.err",   {31'd0, mem_err}, 32'd0);
      tick();
    end
    mem_ready = 1'b1;
    mem_rdata = 32'h1234_5678;
    tick();
    mem_ready = 1'b0;
    check_eq("nto.rw",  {31'd0, RegWriteW}, 32'd1);
    check_eq("nto.res", ResultW, 32'h1234_5678);
`endif

    // Asynchronous reset in the middle of WAIT
    drive_m(1'b1, 1'b0, 1'b1, 5'd8, 32'h0000_0400, 32'd0);
    tick();
    drive_m(1'b0, 1'b1, 1'b0, 5'd0, 32'h0000_0500, 32'h0000_0505);
    check_eq("rst.req_before", {31'd0, mem_req}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("rst_async");
    tick();
    rst = 1'b0;
    drive_m(1'b1, 1'b0, 1'b0, 5'd9, 32'h0000_0ABC, 32'd0);
    tick();
    check_eq("rst.alu_rw",  {31'd0, RegWriteW}, 32'd1);
    check_eq("rst.alu_rd",  {27'd0, RDW}, 32'd9);
    check_eq("rst.alu_res", ResultW, 32'h0000_0ABC);
    check_eq("rst.stall",   {31'd0, StallM}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
